// File: rtl/pc_fetch_gen.sv
// Fetch-stage program counter generator with a small direct-mapped BTB.
// Selects the next fetch PC from trap flush, EX redirect, stall hold,
// BTB-predicted target or sequential PC+4, and trains the BTB from EX.
module pc_fetch_gen #(
    parameter int          XLEN        = 32,
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_flush_valid,
    input  logic [XLEN-1:0] i_flush_pc,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_btb_upd_valid,
    input  logic [XLEN-1:0] i_btb_upd_pc,
    input  logic [XLEN-1:0] i_btb_upd_target,
    input  logic            i_btb_upd_taken,
    output logic [XLEN-1:0] o_pc,
    output logic            o_pc_valid,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target
);

    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    // Current fetch PC and the "first real fetch" qualifier
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_next;
    logic            pc_valid_reg;

    // BTB storage; kept in flops because lookup is combinational and
    // valid/counter bits must clear on asynchronous reset
    logic              valid_reg  [BTB_ENTRIES];
    logic [TAGW-1:0]   tag_reg    [BTB_ENTRIES];
    logic [XLEN-3:0]   target_reg [BTB_ENTRIES];
    logic [1:0]        ctr_reg    [BTB_ENTRIES];

    // Lookup side (indexed by the current fetch PC)
    logic [IDX-1:0]    lk_idx;
    logic [TAGW-1:0]   lk_tag;
    logic              lk_hit;

    // Update side (indexed by the resolved branch PC)
    logic [IDX-1:0]    upd_idx;
    logic [TAGW-1:0]   upd_tag;
    logic              upd_hit;
    logic [BTB_ENTRIES-1:0] upd_sel;

    assign lk_idx  = pc_reg[IDX+1:2];
    assign lk_tag  = pc_reg[XLEN-1:IDX+2];
    assign upd_idx = i_btb_upd_pc[IDX+1:2];
    assign upd_tag = i_btb_upd_pc[XLEN-1:IDX+2];

    assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);

    // One-hot write select per BTB entry
    genvar gi;
    generate
        for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_upd_sel
            assign upd_sel[gi] = i_btb_upd_valid && (upd_idx == IDX'(gi));
        end
    endgenerate

    // Prediction reads the pre-update contents; no write-to-read bypass
    always_comb begin
        lk_hit        = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);
        o_pred_taken  = lk_hit && ctr_reg[lk_idx][1];
        o_pred_target = '0;
        if (o_pred_taken) begin
            o_pred_target = {target_reg[lk_idx], 2'b00};
        end
    end

    // Next-PC priority: flush, redirect, stall, predicted target, PC+4
    always_comb begin
        pc_next = pc_reg + XLEN'(4);
        if (i_flush_valid) begin
            pc_next = {i_flush_pc[XLEN-1:2], 2'b00};
        end else if (i_redirect_valid) begin
            pc_next = {i_redirect_pc[XLEN-1:2], 2'b00};
        end else if (i_stall) begin
            pc_next = pc_reg;
        end else if (o_pred_taken) begin
            pc_next = o_pred_target;
        end
    end

    // PC register; the first edge after reset only raises valid and keeps RESET_VEC
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc_reg       <= XLEN'({RESET_VEC[31:2], 2'b00});
            pc_valid_reg <= 1'b0;
        end else begin
            pc_valid_reg <= 1'b1;
            if (pc_valid_reg) begin
                pc_reg <= pc_next;
            end
        end
    end

    // BTB training: saturating counters on hit, allocate on taken miss
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_reg[i]  <= 1'b0;
                tag_reg[i]    <= '0;
                target_reg[i] <= '0;
                ctr_reg[i]    <= 2'b00;
            end
        end else begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                if (upd_sel[i]) begin
                    if (upd_hit) begin
                        if (i_btb_upd_taken) begin
                            if (ctr_reg[i] != 2'b11) begin
                                ctr_reg[i] <= ctr_reg[i] + 2'd1;
                            end
                            target_reg[i] <= i_btb_upd_target[XLEN-1:2];
                        end else if (ctr_reg[i] != 2'b00) begin
                            ctr_reg[i] <= ctr_reg[i] - 2'd1;
                        end
                    end else if (i_btb_upd_taken) begin
                        valid_reg[i]  <= 1'b1;
                        tag_reg[i]    <= upd_tag;
                        target_reg[i] <= i_btb_upd_target[XLEN-1:2];
                        ctr_reg[i]    <= 2'b10;
                    end
                end
            end
        end
    end

    assign o_pc       = pc_reg;
    assign o_pc_valid = pc_valid_reg;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed testbench for pc_fetch_gen (RESET_VEC=0x100, 8-entry BTB).
module tb_pc_fetch_gen;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pred_taken;
    logic [31:0] pred_target;

    int checks_cnt = 0;
    int errors_cnt = 0;

    pc_fetch_gen #(
        .XLEN        (32),
        .RESET_VEC   (32'h0000_0100),
        .BTB_ENTRIES (8)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_stall          (stall),
        .i_flush_valid    (flush_valid),
        .i_flush_pc       (flush_pc),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .i_btb_upd_valid  (upd_valid),
        .i_btb_upd_pc     (upd_pc),
        .i_btb_upd_target (upd_target),
        .i_btb_upd_taken  (upd_taken),
        .o_pc             (pc),
        .o_pc_valid       (pc_valid),
        .o_pred_taken     (pred_taken),
        .o_pred_target    (pred_target)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance one clock edge and settle 1 ns past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        stall          = 1'b0;
        flush_valid    = 1'b0;
        redirect_valid = 1'b0;
        upd_valid      = 1'b0;
        upd_taken      = 1'b0;
    endtask

    task automatic do_upd(input logic [31:0] p, input logic [31:0] t, input logic tk);
        upd_valid  = 1'b1;
        upd_pc     = p;
        upd_target = t;
        upd_taken  = tk;
        step();
        upd_valid  = 1'b0;
    endtask

    task automatic jump_to(input logic [31:0] p);
        redirect_valid = 1'b1;
        redirect_pc    = p;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flush_pc = '0; redirect_pc = '0; upd_pc = '0; upd_target = '0;
        clear_ctl();
        #2;
        check_val("rst_pc", pc, 32'h100);
        check_val("rst_valid", {31'b0, pc_valid}, 32'h0);
        check_val("rst_pred", {31'b0, pred_taken}, 32'h0);
        check_val("rst_tgt", pred_target, 32'h0);

        // Release reset: RESET_VEC held one cycle with valid, then sequential
        @(posedge clk); #1;
        rst = 1'b0;
        step();
        check_val("rel_pc0", pc, 32'h100);
        check_val("rel_valid", {31'b0, pc_valid}, 32'h1);
        step(); check_val("rel_pc1", pc, 32'h104);
        step(); check_val("rel_pc2", pc, 32'h108);

        // Asynchronous reset mid-run
        rst = 1'b1;
        #1;
        check_val("arst_pc", pc, 32'h100);
        check_val("arst_valid", {31'b0, pc_valid}, 32'h0);
        step(); step();
        rst = 1'b0;
        step();
        check_val("rel2_pc0", pc, 32'h100);
        check_val("rel2_valid", {31'b0, pc_valid}, 32'h1);
        step(); check_val("rel2_pc1", pc, 32'h104);
        step(); check_val("rel2_pc2", pc, 32'h108);

        // Stall holds, redirect overrides stall and is aligned
        jump_to(32'h200);
        check_val("jmp_200", pc, 32'h200);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("stall_hold", pc, 32'h200);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h403;
        step();
        check_val("redir_over_stall", pc, 32'h400);
        clear_ctl();

        // Flush beats redirect; redirect never applied later
        flush_valid = 1'b1; flush_pc = 32'h80;
        redirect_valid = 1'b1; redirect_pc = 32'h500;
        step();
        check_val("flush_win", pc, 32'h80);
        clear_ctl();
        step(); check_val("post_flush1", pc, 32'h84);
        check_val("no_pred_84", {31'b0, pred_taken}, 32'h0);
        step(); check_val("post_flush2", pc, 32'h88);

        // BTB allocate and predict
        do_upd(32'h40, 32'h1000, 1'b1);
        jump_to(32'h40);
        check_val("alloc_pred", {31'b0, pred_taken}, 32'h1);
        check_val("alloc_tgt", pred_target, 32'h1000);
        step();
        check_val("follow_pred", pc, 32'h1000);
        check_val("miss_1000", {31'b0, pred_taken}, 32'h0);

        // Two not-taken: 10 -> 01 -> 00
        do_upd(32'h40, 32'h0, 1'b0);
        do_upd(32'h40, 32'h0, 1'b0);
        jump_to(32'h40);
        check_val("nt_pred", {31'b0, pred_taken}, 32'h0);
        check_val("nt_tgt", pred_target, 32'h0);
        step();
        check_val("nt_seq", pc, 32'h44);

        // Four taken: 00->01->10->11->11 (last one rewrites target)
        do_upd(32'h40, 32'h1000, 1'b1);
        do_upd(32'h40, 32'h1000, 1'b1);
        do_upd(32'h40, 32'h1000, 1'b1);
        do_upd(32'h40, 32'h2000, 1'b1);
        // One not-taken: saturated 11 -> 10, still taken, target kept
        do_upd(32'h40, 32'h0, 1'b0);
        jump_to(32'h40);
        check_val("sat_pred", {31'b0, pred_taken}, 32'h1);
        check_val("sat_tgt", pred_target, 32'h2000);
        // Second not-taken: 10 -> 01
        do_upd(32'h40, 32'h0, 1'b0);
        jump_to(32'h40);
        check_val("sat_dec", {31'b0, pred_taken}, 32'h0);

        // Alias: 0x60 shares index 0, evicts 0x40 (update and redirect same edge)
        upd_valid = 1'b1; upd_pc = 32'h60; upd_target = 32'h3000; upd_taken = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        clear_ctl();
        check_val("evict_pc", pc, 32'h40);
        check_val("evict_miss", {31'b0, pred_taken}, 32'h0);
        jump_to(32'h60);
        check_val("alias_pred", {31'b0, pred_taken}, 32'h1);
        check_val("alias_tgt", pred_target, 32'h3000);

        // Collision: update lookup index while stalled; change visible next cycle
        stall = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h60; upd_target = 32'h0; upd_taken = 1'b0;
        #1;
        check_val("coll_pre", {31'b0, pred_taken}, 32'h1);
        @(posedge clk); #1;
        clear_ctl();
        check_val("coll_pc", pc, 32'h60);
        check_val("coll_post", {31'b0, pred_taken}, 32'h0);

        // PC+4 wraps
        jump_to(32'hFFFF_FFFC);
        check_val("wrap_pre", pc, 32'hFFFF_FFFC);
        step();
        check_val("wrap_post", pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
